// File: rtl/ghost_position_update_pkg.sv
// ghost_position_update_pkg: direction codes, FSM states and screen/tile defaults
// shared between the ghost chaser and the ghost position updater.
package ghost_position_update_pkg;

   localparam logic [3:0] ZEROS = 4'b0000;
   localparam logic [3:0] RIGHT = 4'b0001;
   localparam logic [3:0] UP    = 4'b0010;
   localparam logic [3:0] DOWN  = 4'b0100;
   localparam logic [3:0] LEFT  = 4'b1000;

   localparam int SCREEN_W_DEF = 640;
   localparam int TILE_DEF     = 16;

   typedef enum logic [1:0] {
      HOLD  = 2'd0,
      ALIGN = 2'd1,
      MOVE  = 2'd2
   } state_e;

   function automatic logic is_onehot(input logic [3:0] d);
      return (d != ZEROS) && ((d & (d - 4'd1)) == ZEROS);
   endfunction

endpackage

// File: rtl/ghost_position_update_abs_diff_cmp.sv
// abs_diff_cmp: unsigned |a - b| at one extra bit, flagged when below THRESH.
module abs_diff_cmp #(
   parameter int W      = 11,
   parameter int THRESH = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         lt_o
);

   localparam logic [W:0] TH = (W+1)'(THRESH);

   logic [W:0] diff;

   always_comb begin
      diff = (a_i >= b_i) ? {1'b0, a_i} - {1'b0, b_i} : {1'b0, b_i} - {1'b0, a_i};
      lt_o = diff < TH;
   end

endmodule

// File: rtl/ghost_position_update.sv
// ghost_position_update: steps the ghost sprite one STEP per move_tick, accepting new
// directions only on tile-aligned positions, with horizontal wrap and pacman contact.
module ghost_position_update
   import ghost_position_update_pkg::*;
#(
   parameter logic [10:0] START_X    = 11'd320,
   parameter logic [9:0]  START_Y    = 10'd240,
   parameter int          TILE       = TILE_DEF,
   parameter int          STEP       = 1,
   parameter int          SCREEN_W   = SCREEN_W_DEF,
   parameter int          CATCH_DIST = 8,
   parameter int          HOLD_TICKS = 60
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        move_tick,
   input  logic [3:0]  move_direction,
   input  logic [3:0]  valid_moves,
   input  logic        respawn,
   input  logic [10:0] pacman_pos_x,
   input  logic [9:0]  pacman_pos_y,
   output logic [10:0] ghost_pos_x,
   output logic [9:0]  ghost_pos_y,
   output logic [3:0]  curr_direction,
   output logic        moving,
   output logic        aligned,
   output logic        caught
);

   localparam logic [15:0] NSTEP     = 16'(TILE / STEP);
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_TICKS - 1);
   localparam logic [10:0] X_LAST    = 11'(SCREEN_W - TILE);
   localparam logic [10:0] SX        = 11'(STEP);
   localparam logic [9:0]  SY        = 10'(STEP);

   state_e      state_q, state_d;
   logic [10:0] x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic [3:0]  dir_q, dir_d;
   logic [15:0] hold_q, hold_d;
   logic [15:0] step_q, step_d;
   logic        caught_q, near_x, near_y;

   function automatic logic [10:0] step_x(input logic [10:0] x, input logic [3:0] d);
      return (d == RIGHT) ? x + SX : (d == LEFT) ? x - SX : x;
   endfunction

   function automatic logic [9:0] step_y(input logic [9:0] y, input logic [3:0] d);
      return (d == DOWN) ? y + SY : (d == UP) ? y - SY : y;
   endfunction

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      dir_d   = dir_q;
      hold_d  = hold_q;
      step_d  = step_q;
      if (respawn) begin
         state_d = HOLD;
         x_d     = START_X;
         y_d     = START_Y;
         dir_d   = ZEROS;
         hold_d  = '0;
         step_d  = '0;
      end else if (move_tick) begin
         case (state_q)
            HOLD: begin
               hold_d  = (hold_q == HOLD_LAST) ? '0 : hold_q + 16'd1;
               state_d = (hold_q == HOLD_LAST) ? ALIGN : HOLD;
            end
            ALIGN: begin
               // wrap wins over valid_moves: the tunnel exits are never marked legal
               if (move_direction == LEFT && x_q == '0) begin
                  x_d   = X_LAST;
                  dir_d = LEFT;
               end else if (move_direction == RIGHT && x_q == X_LAST) begin
                  x_d   = '0;
                  dir_d = RIGHT;
               end else if (is_onehot(move_direction) && |(move_direction & valid_moves)) begin
                  dir_d   = move_direction;
                  x_d     = step_x(x_q, move_direction);
                  y_d     = step_y(y_q, move_direction);
                  step_d  = (NSTEP == 16'd1) ? '0 : 16'd1;
                  state_d = (NSTEP == 16'd1) ? ALIGN : MOVE;
               end
            end
            MOVE: begin
               x_d     = step_x(x_q, dir_q);
               y_d     = step_y(y_q, dir_q);
               step_d  = (step_q + 16'd1 == NSTEP) ? '0 : step_q + 16'd1;
               state_d = (step_q + 16'd1 == NSTEP) ? ALIGN : MOVE;
            end
            default: state_d = HOLD;
         endcase
      end
   end

   abs_diff_cmp #(.W(11), .THRESH(CATCH_DIST)) u_cmp_x (
      .a_i  (x_q),
      .b_i  (pacman_pos_x),
      .lt_o (near_x)
   );

   abs_diff_cmp #(.W(10), .THRESH(CATCH_DIST)) u_cmp_y (
      .a_i  (y_q),
      .b_i  (pacman_pos_y),
      .lt_o (near_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= HOLD;
         x_q      <= START_X;
         y_q      <= START_Y;
         dir_q    <= ZEROS;
         hold_q   <= '0;
         step_q   <= '0;
         caught_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         dir_q    <= dir_d;
         hold_q   <= hold_d;
         step_q   <= step_d;
         caught_q <= near_x & near_y;
      end
   end

   assign ghost_pos_x    = x_q;
   assign ghost_pos_y    = y_q;
   assign curr_direction = dir_q;
   assign moving         = (state_q == MOVE);
   assign aligned        = (state_q == ALIGN);
   assign caught         = caught_q;

endmodule

// File: tb/tb_ghost_position_update.sv
// tb_ghost_position_update: directed test-plan sequences plus randomized traffic, all
// checked against a pixel-level ghost model (alignment inferred from the tile grid).
module tb_ghost_position_update;
   import ghost_position_update_pkg::*;

   localparam int FX = 1000;
   localparam int FY = 900;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        move_tick = 1'b0;
   logic [3:0]  move_direction = 4'd0;
   logic [3:0]  valid_moves = 4'd0;
   logic        respawn = 1'b0;
   logic [10:0] pacman_pos_x = 11'd0;
   logic [9:0]  pacman_pos_y = 10'd0;
   logic [10:0] ghost_pos_x;
   logic [9:0]  ghost_pos_y;
   logic [3:0]  curr_direction;
   logic        moving, aligned, caught;

   int checks = 0;
   int errors = 0;

   int         m_x = 320;
   int         m_y = 240;
   int         m_hold = 60;
   logic [3:0] m_dir = 4'd0;
   logic       m_caught = 1'b0;

   always #5 clk = ~clk;

   ghost_position_update dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .move_tick      (move_tick),
      .move_direction (move_direction),
      .valid_moves    (valid_moves),
      .respawn        (respawn),
      .pacman_pos_x   (pacman_pos_x),
      .pacman_pos_y   (pacman_pos_y),
      .ghost_pos_x    (ghost_pos_x),
      .ghost_pos_y    (ghost_pos_y),
      .curr_direction (curr_direction),
      .moving         (moving),
      .aligned        (aligned),
      .caught         (caught)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int adiff(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   function automatic int popcount4(input logic [3:0] d);
      return int'(d[0]) + int'(d[1]) + int'(d[2]) + int'(d[3]);
   endfunction

   task automatic m_move(input logic [3:0] d);
      if (d == RIGHT) m_x = m_x + 1;
      else if (d == LEFT) m_x = m_x - 1;
      else if (d == DOWN) m_y = (m_y + 1) % 1024;
      else if (d == UP) m_y = (m_y + 1023) % 1024;
   endtask

   task automatic m_respawn();
      m_x = 320;
      m_y = 240;
      m_dir = 4'd0;
      m_hold = 60;
   endtask

   // ghost is free-running and between tiles exactly when it is off the 16-px grid
   task automatic model_step(input logic t, input logic [3:0] d, input logic [3:0] v,
                             input logic r, input int px, input int py);
      m_caught = (adiff(m_x, px) < 8) && (adiff(m_y, py) < 8);
      if (r) m_respawn();
      else if (t) begin
         if (m_hold > 0) m_hold--;
         else if (m_x % 16 == 0 && m_y % 16 == 0) begin
            if (d == LEFT && m_x == 0) begin
               m_x = 624;
               m_dir = d;
            end else if (d == RIGHT && m_x == 624) begin
               m_x = 0;
               m_dir = d;
            end else if (popcount4(d) == 1 && (d & v) != 4'd0) begin
               m_dir = d;
               m_move(d);
            end
         end else m_move(m_dir);
      end
   endtask

   task automatic compare_all();
      logic on_grid;
      on_grid = (m_x % 16 == 0) && (m_y % 16 == 0);
      chk("pos_x", 32'(ghost_pos_x), m_x);
      chk("pos_y", 32'(ghost_pos_y), m_y);
      chk("curr_direction", 32'(curr_direction), 32'(m_dir));
      chk("aligned", 32'(aligned), 32'(m_hold == 0 && on_grid));
      chk("moving", 32'(moving), 32'(m_hold == 0 && !on_grid));
      chk("caught", 32'(caught), 32'(m_caught));
   endtask

   task automatic cyc(input logic t, input logic [3:0] d, input logic [3:0] v,
                      input logic r, input int px, input int py);
      move_tick = t;
      move_direction = d;
      valid_moves = v;
      respawn = r;
      pacman_pos_x = 11'(px);
      pacman_pos_y = 10'(py);
      @(posedge clk);
      model_step(t, d, v, r, px, py);
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      m_respawn();
      m_caught = 1'b0;
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();
      chk("rst_x", 32'(ghost_pos_x), 320);
      chk("rst_y", 32'(ghost_pos_y), 240);
      chk("rst_aligned", 32'(aligned), 0);
      for (int i = 0; i < 59; i++) cyc(1'b1, ZEROS, 4'd0, 1'b0, FX, FY);
      chk("hold59_x", 32'(ghost_pos_x), 320);
      chk("hold59_aligned", 32'(aligned), 0);
      cyc(1'b1, ZEROS, 4'd0, 1'b0, FX, FY);
      chk("hold60_aligned", 32'(aligned), 1);
      chk("hold60_dir", 32'(curr_direction), 0);
      cyc(1'b1, RIGHT, 4'b0011, 1'b0, FX, FY);
      chk("first_step_x", 32'(ghost_pos_x), 321);
      chk("first_step_moving", 32'(moving), 1);
      for (int i = 0; i < 4; i++) cyc(1'b1, RIGHT, 4'b0011, 1'b0, FX, FY);
      for (int i = 0; i < 11; i++) cyc(1'b1, UP, 4'b0010, 1'b0, FX, FY);
      chk("tile_end_x", 32'(ghost_pos_x), 336);
      chk("tile_end_aligned", 32'(aligned), 1);
      chk("tile_end_dir", 32'(curr_direction), 32'(RIGHT));
      cyc(1'b1, UP, 4'b0010, 1'b0, FX, FY);
      chk("turn_up_y", 32'(ghost_pos_y), 239);
      chk("turn_up_dir", 32'(curr_direction), 32'(UP));
      for (int i = 0; i < 15; i++) cyc(1'b1, UP, 4'b0010, 1'b0, FX, FY);
      cyc(1'b1, 4'b1010, 4'b1111, 1'b0, FX, FY);
      chk("multihot_x", 32'(ghost_pos_x), 336);
      chk("multihot_dir", 32'(curr_direction), 32'(UP));
      cyc(1'b1, DOWN, 4'b1001, 1'b0, FX, FY);
      chk("illegal_y", 32'(ghost_pos_y), 224);
      chk("illegal_dir", 32'(curr_direction), 32'(UP));
      for (int i = 0; i < 336; i++) cyc(1'b1, LEFT, 4'b1000, 1'b0, FX, FY);
      chk("walk_left_x", 32'(ghost_pos_x), 0);
      cyc(1'b1, LEFT, 4'b0000, 1'b0, FX, FY);
      chk("wrap_left_x", 32'(ghost_pos_x), 624);
      chk("wrap_left_aligned", 32'(aligned), 1);
      cyc(1'b1, RIGHT, 4'b0000, 1'b0, FX, FY);
      chk("wrap_right_x", 32'(ghost_pos_x), 0);
      chk("wrap_right_dir", 32'(curr_direction), 32'(RIGHT));
      cyc(1'b0, ZEROS, 4'd0, 1'b1, FX, FY);
      cyc(1'b0, ZEROS, 4'd0, 1'b0, 327, 247);
      chk("contact_near", 32'(caught), 1);
      cyc(1'b0, ZEROS, 4'd0, 1'b0, 328, 240);
      chk("contact_far", 32'(caught), 0);
      for (int i = 0; i < 60; i++) cyc(1'b1, ZEROS, 4'd0, 1'b0, FX, FY);
      for (int i = 0; i < 4; i++) cyc(1'b1, RIGHT, 4'b0001, 1'b0, FX, FY);
      cyc(1'b1, RIGHT, 4'b0001, 1'b1, FX, FY);
      chk("respawn_x", 32'(ghost_pos_x), 320);
      chk("respawn_moving", 32'(moving), 0);
      chk("respawn_aligned", 32'(aligned), 0);
      for (int i = 0; i < 60; i++) cyc(1'b1, ZEROS, 4'd0, 1'b0, FX, FY);
      for (int i = 0; i < 5; i++) cyc(1'b1, DOWN, 4'b0100, 1'b0, FX, FY);
      do_reset();
      chk("midmove_rst_y", 32'(ghost_pos_y), 240);
      for (int n = 0; n < 5000; n++) begin
         logic       t, r;
         logic [3:0] d, v;
         int         px, py;
         t = ($urandom_range(0, 3) != 0);
         d = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(4'd1 << $urandom_range(0, 3));
         v = 4'($urandom);
         r = ($urandom_range(0, 399) == 0);
         px = m_x + int'($urandom_range(0, 24)) - 12;
         py = m_y + int'($urandom_range(0, 24)) - 12;
         px = (px < 0) ? 0 : (px > 2047) ? 2047 : px;
         py = (py < 0) ? 0 : (py > 1023) ? 1023 : py;
         if ($urandom_range(0, 1499) == 0) do_reset();
         else cyc(t, d, v, r, px, py);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
